// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/ERR).
// Sequences one instruction at a time, waits on imem/dmem ready handshakes
// with an optional timeout, and counts retired instructions.
// Optional feature macro: CTRL_PERF_EN adds cycle_cnt / stall_cnt counters;
// without it both outputs are tied to zero and no counter flops exist.
module mc_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             IRWE,
  output logic             PCWE,
  output logic [2:0]       NPCOp,
  output logic             immExtOp,
  output logic             RFWE,
  output logic             DMWE,
  output logic [3:0]       ALUOp,
  output logic [2:0]       DMOp,
  output logic [1:0]       WRSel,
  output logic [1:0]       RFWDSel,
  output logic             BSel,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             err,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  // Wait counter only needs to reach TIMEOUT-1.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  typedef struct packed {
    logic       legal;
    logic       is_j;
    logic       is_jr;
    logic       is_jal;
    logic       is_beq;
    logic       is_load;
    logic       is_store;
    logic [3:0] alu_op;
    logic [2:0] dm_op;
    logic [1:0] wr_sel;
    logic [1:0] rfwd_sel;
    logic       bsel;
    logic       imm_sext;
  } dec_t;

  state_t            cur, nxt;
  dec_t              dec;
  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting, timeout_hit;
  logic              imem_req_c, dmem_req_c, irwe_c, pcwe_c, rfwe_c, dmwe_c, illegal_c;
  logic [2:0]        npc_op;

  // Instruction decode; depends only on opcode/funct so select fields stay
  // stable for the whole instruction. Undefined encodings leave legal=0.
  always_comb begin
    dec = '0;
    case (opcode)
      6'b000000: begin
        dec.wr_sel = 2'b01;
        case (funct)
          6'b100000: begin dec.legal = 1'b1; dec.alu_op = 4'b0000; end
          6'b100010: begin dec.legal = 1'b1; dec.alu_op = 4'b0001; end
          6'b101010: begin dec.legal = 1'b1; dec.alu_op = 4'b0011; end
          6'b000000: begin dec.legal = 1'b1; dec.alu_op = 4'b0101; end
          6'b001000: begin dec.legal = 1'b1; dec.is_jr  = 1'b1;    end
          default:   dec.wr_sel = 2'b00;
        endcase
      end
      6'b001101: begin dec.legal = 1'b1; dec.alu_op = 4'b0010; dec.bsel = 1'b1; end
      6'b001111: begin dec.legal = 1'b1; dec.alu_op = 4'b0100; dec.bsel = 1'b1; end
      6'b100011: begin
        dec.legal = 1'b1; dec.is_load = 1'b1; dec.bsel = 1'b1; dec.imm_sext = 1'b1;
        dec.rfwd_sel = 2'b01; dec.dm_op = 3'b000;
      end
      6'b100000: begin
        dec.legal = 1'b1; dec.is_load = 1'b1; dec.bsel = 1'b1; dec.imm_sext = 1'b1;
        dec.rfwd_sel = 2'b01; dec.dm_op = 3'b001;
      end
      6'b100100: begin
        dec.legal = 1'b1; dec.is_load = 1'b1; dec.bsel = 1'b1; dec.imm_sext = 1'b1;
        dec.rfwd_sel = 2'b01; dec.dm_op = 3'b101;
      end
      6'b101011: begin
        dec.legal = 1'b1; dec.is_store = 1'b1; dec.bsel = 1'b1; dec.imm_sext = 1'b1;
        dec.dm_op = 3'b000;
      end
      6'b101000: begin
        dec.legal = 1'b1; dec.is_store = 1'b1; dec.bsel = 1'b1; dec.imm_sext = 1'b1;
        dec.dm_op = 3'b001;
      end
      6'b000100: begin
        dec.legal = 1'b1; dec.is_beq = 1'b1; dec.alu_op = 4'b0001; dec.imm_sext = 1'b1;
      end
      6'b000010: begin dec.legal = 1'b1; dec.is_j = 1'b1; end
      6'b000011: begin
        dec.legal = 1'b1; dec.is_jal = 1'b1; dec.wr_sel = 2'b10; dec.rfwd_sel = 2'b10;
      end
      default: dec = '0;
    endcase
  end

  // Next-PC source; illegal opcodes fall through to pc+4.
  always_comb begin
    npc_op = 3'b000;
    if (dec.is_j)        npc_op = 3'b010;
    else if (dec.is_jr)  npc_op = 3'b100;
    else if (dec.is_jal) npc_op = 3'b011;
    else if (dec.is_beq) npc_op = zero ? 3'b001 : 3'b000;
  end

  assign waiting     = ((cur == S_FETCH) && !imem_ready) || ((cur == S_MEM) && !dmem_ready);
  // Ready in the expiry cycle wins because waiting is already low then.
  assign timeout_hit = (TIMEOUT != 0) && waiting && (wait_cnt == WAIT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur <= S_FETCH;
    else        cur <= nxt;
  end

  // Next-state and per-state enables.
  always_comb begin
    nxt        = cur;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    irwe_c     = 1'b0;
    pcwe_c     = 1'b0;
    rfwe_c     = 1'b0;
    dmwe_c     = 1'b0;
    illegal_c  = 1'b0;
    case (cur)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          irwe_c = 1'b1;
          nxt    = S_DECODE;
        end else if (timeout_hit) begin
          nxt = S_ERR;
        end
      end
      S_DECODE: begin
        if (!dec.legal) begin
          illegal_c = 1'b1;
          pcwe_c    = 1'b1;
          nxt       = S_FETCH;
        end else if (dec.is_j || dec.is_jr) begin
          pcwe_c = 1'b1;
          nxt    = S_FETCH;
        end else if (dec.is_jal) begin
          nxt = S_WB;
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (dec.is_beq) begin
          pcwe_c = 1'b1;
          nxt    = S_FETCH;
        end else if (dec.is_load || dec.is_store) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmwe_c     = dec.is_store;
        if (dmem_ready) begin
          if (dec.is_store) begin
            pcwe_c = 1'b1;
            nxt    = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end else if (timeout_hit) begin
          nxt = S_ERR;
        end
      end
      S_WB: begin
        rfwe_c = 1'b1;
        pcwe_c = 1'b1;
        nxt    = S_FETCH;
      end
      S_ERR:   nxt = S_ERR;
      default: nxt = S_FETCH;
    endcase
  end

  // Wait counter: counts stalled cycles, clears whenever the state moves.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       wait_cnt <= '0;
    else if (nxt != cur)              wait_cnt <= '0;
    else if (waiting && TIMEOUT != 0) wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  // Sticky timeout flag and retired-instruction counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err       <= 1'b0;
      instr_cnt <= '0;
    end else begin
      if (timeout_hit) err <= 1'b1;
      if (pcwe_c)      instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

`ifdef CTRL_PERF_EN
  logic [CNT_W-1:0] cycle_q, stall_q;

  // Performance counters: live cycles outside ERR and handshake stall cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q <= '0;
      stall_q <= '0;
    end else begin
      if (cur != S_ERR) cycle_q <= cycle_q + CNT_W'(1);
      if (waiting)      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign cycle_cnt = cycle_q;
  assign stall_cnt = stall_q;
`else
  assign cycle_cnt = '0;
  assign stall_cnt = '0;
`endif

  // Enables drop the moment reset asserts, even mid-instruction.
  assign imem_req = reset & imem_req_c;
  assign dmem_req = reset & dmem_req_c;
  assign IRWE     = reset & irwe_c;
  assign PCWE     = reset & pcwe_c;
  assign RFWE     = reset & rfwe_c;
  assign DMWE     = reset & dmwe_c;
  assign illegal  = reset & illegal_c;

  assign NPCOp    = npc_op;
  assign immExtOp = dec.imm_sext;
  assign ALUOp    = dec.alu_op;
  assign DMOp     = dec.dm_op;
  assign WRSel    = dec.wr_sel;
  assign RFWDSel  = dec.rfwd_sel;
  assign BSel     = dec.bsel;
  assign state    = cur;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl, built with TIMEOUT=4 so the timeout path is short.
module tb_mc_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        zero, imem_ready, dmem_ready;
  logic        imem_req, dmem_req, IRWE, PCWE, immExtOp, RFWE, DMWE, BSel, illegal, err;
  logic [2:0]  NPCOp, DMOp, state;
  logic [3:0]  ALUOp;
  logic [1:0]  WRSel, RFWDSel;
  logic [31:0] instr_cnt, cycle_cnt, stall_cnt;
  int          total = 0;
  int          bad   = 0;

  mc_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .IRWE(IRWE), .PCWE(PCWE),
    .NPCOp(NPCOp), .immExtOp(immExtOp), .RFWE(RFWE), .DMWE(DMWE), .ALUOp(ALUOp),
    .DMOp(DMOp), .WRSel(WRSel), .RFWDSel(RFWDSel), .BSel(BSel), .state(state),
    .illegal(illegal), .err(err), .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; opcode = '0; funct = '0; zero = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    #12;
    chk("rst_state", 32'(state), 0);
    chk("rst_ireq",  32'(imem_req), 0);
    chk("rst_icnt",  instr_cnt, 0);
    chk("rst_err",   32'(err), 0);
`ifndef CTRL_PERF_EN
    chk("rst_cyc",   cycle_cnt, 0);
    chk("rst_stall", stall_cnt, 0);
`endif

    // add, ready=1: FETCH DECODE EXEC WB
    reset = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; funct = 6'b100000;
    #1;
    chk("add_f_st", 32'(state), 0);
    chk("add_f_req", 32'(imem_req), 1);
    chk("add_f_irwe", 32'(IRWE), 1);
    cyc(); chk("add_d_st", 32'(state), 1); chk("add_d_pcwe", 32'(PCWE), 0);
    cyc(); chk("add_e_st", 32'(state), 2);
    cyc(); chk("add_w_st", 32'(state), 4);
    chk("add_w_rfwe", 32'(RFWE), 1); chk("add_w_wrsel", 32'(WRSel), 1);
    chk("add_w_alu", 32'(ALUOp), 0); chk("add_w_pcwe", 32'(PCWE), 1);
    cyc(); chk("add_done_st", 32'(state), 0); chk("add_icnt", instr_cnt, 1);

    // lw, dmem_ready low for 3 MEM cycles; ready arrives on the expiry cycle
    opcode = 6'b100011; dmem_ready = 1'b0;
    cyc(); cyc(); cyc();
    chk("lw_m1_st", 32'(state), 3); chk("lw_m1_dmwe", 32'(DMWE), 0);
    chk("lw_m1_dreq", 32'(dmem_req), 1);
    cyc(); chk("lw_m2_st", 32'(state), 3); chk("lw_m2_dmwe", 32'(DMWE), 0);
    cyc(); chk("lw_m3_st", 32'(state), 3);
    cyc(); chk("lw_m4_st", 32'(state), 3);
    dmem_ready = 1'b1; #1;
    chk("lw_m4_pcwe", 32'(PCWE), 0); chk("lw_m4_dmwe", 32'(DMWE), 0);
    cyc(); chk("lw_wb_st", 32'(state), 4); chk("lw_wb_rfwd", 32'(RFWDSel), 1);
    chk("lw_wb_rfwe", 32'(RFWE), 1);
    cyc(); chk("lw_done_st", 32'(state), 0); chk("lw_icnt", instr_cnt, 2);

    // beq taken / not taken
    opcode = 6'b000100; zero = 1'b1;
    cyc(); cyc();
    chk("beq1_st", 32'(state), 2); chk("beq1_pcwe", 32'(PCWE), 1); chk("beq1_npc", 32'(NPCOp), 1);
    chk("beq1_sext", 32'(immExtOp), 1);
    cyc(); chk("beq1_done", 32'(state), 0); chk("beq1_icnt", instr_cnt, 3);
    zero = 1'b0;
    cyc(); cyc();
    chk("beq0_st", 32'(state), 2); chk("beq0_pcwe", 32'(PCWE), 1); chk("beq0_npc", 32'(NPCOp), 0);
    cyc(); chk("beq0_done", 32'(state), 0); chk("beq0_icnt", instr_cnt, 4);

    // jal: DECODE then WB
    opcode = 6'b000011;
    cyc(); chk("jal_d_st", 32'(state), 1); chk("jal_d_pcwe", 32'(PCWE), 0);
    cyc(); chk("jal_w_st", 32'(state), 4); chk("jal_wrsel", 32'(WRSel), 2);
    chk("jal_rfwd", 32'(RFWDSel), 2); chk("jal_npc", 32'(NPCOp), 3);
    chk("jal_rfwe", 32'(RFWE), 1); chk("jal_pcwe", 32'(PCWE), 1);
    cyc(); chk("jal_done", 32'(state), 0); chk("jal_icnt", instr_cnt, 5);

    // sb: DMWE held until dmem_ready
    opcode = 6'b101000; dmem_ready = 1'b0;
    cyc(); cyc(); cyc();
    chk("sb_m1_st", 32'(state), 3); chk("sb_m1_dmwe", 32'(DMWE), 1);
    chk("sb_m1_dmop", 32'(DMOp), 1); chk("sb_m1_pcwe", 32'(PCWE), 0);
    chk("sb_bsel", 32'(BSel), 1);
    cyc(); chk("sb_m2_dmwe", 32'(DMWE), 1);
    dmem_ready = 1'b1; #1;
    chk("sb_m2_pcwe", 32'(PCWE), 1);
    cyc(); chk("sb_done", 32'(state), 0); chk("sb_icnt", instr_cnt, 6);

    // illegal opcode
    opcode = 6'b111111;
    cyc(); chk("ill_st", 32'(state), 1); chk("ill_flag", 32'(illegal), 1);
    chk("ill_pcwe", 32'(PCWE), 1); chk("ill_npc", 32'(NPCOp), 0);
    chk("ill_rfwe", 32'(RFWE), 0); chk("ill_dmwe", 32'(DMWE), 0);
    cyc(); chk("ill_done", 32'(state), 0); chk("ill_flag_off", 32'(illegal), 0);
    chk("ill_icnt", instr_cnt, 7);

    // j and jr: two cycles each
    opcode = 6'b000010;
    cyc(); chk("j_pcwe", 32'(PCWE), 1); chk("j_npc", 32'(NPCOp), 2);
    cyc(); chk("j_done", 32'(state), 0); chk("j_icnt", instr_cnt, 8);
    opcode = 6'b000000; funct = 6'b001000;
    cyc(); chk("jr_pcwe", 32'(PCWE), 1); chk("jr_npc", 32'(NPCOp), 4);
    cyc(); chk("jr_done", 32'(state), 0); chk("jr_icnt", instr_cnt, 9);

    // sw interrupted by reset while in MEM
    opcode = 6'b101011; dmem_ready = 1'b0;
    cyc(); cyc(); cyc();
    chk("sw_m_st", 32'(state), 3); chk("sw_m_dmwe", 32'(DMWE), 1);
    #2; reset = 1'b0; #1;
    chk("swrst_dmwe", 32'(DMWE), 0); chk("swrst_dreq", 32'(dmem_req), 0);
    chk("swrst_st", 32'(state), 0); chk("swrst_icnt", instr_cnt, 0);
    #2; reset = 1'b1; imem_ready = 1'b0; #1;
    chk("rel_st", 32'(state), 0); chk("rel_ireq", 32'(imem_req), 1);

    // timeout: 4 FETCH wait cycles then ERR
    cyc(); chk("to_w2", 32'(state), 0);
    cyc(); chk("to_w3", 32'(state), 0);
    cyc(); chk("to_w4", 32'(state), 0); chk("to_w4_err", 32'(err), 0);
    cyc(); chk("to_err_st", 32'(state), 5); chk("to_err", 32'(err), 1);
    chk("to_pcwe", 32'(PCWE), 0); chk("to_ireq", 32'(imem_req), 0);
    imem_ready = 1'b1;
    cyc(); chk("to_hold_st", 32'(state), 5); chk("to_hold_err", 32'(err), 1);
    chk("to_hold_irwe", 32'(IRWE), 0);
    reset = 1'b0; #1;
    chk("to_rst_st", 32'(state), 0); chk("to_rst_err", 32'(err), 0);
    #2; reset = 1'b1; #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
